// File: rtl/req_arbiter.sv
// req_arbiter: round-robin arbiter that serialises requester pulls onto one shared source
// and returns the fetched data with a one-cycle ack pulse to the granted requester.
module req_arbiter #(
    parameter int data_width = 32,
    parameter int num_req = 4,
    parameter int count_width = 32,
    localparam int gw = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_req-1:0]             mask,
    input  logic [num_req-1:0]             req,
    output logic [num_req-1:0]             ack,
    output logic [data_width-1:0]          dout,
    output logic                           src_req,
    input  logic                           src_ack,
    input  logic [data_width-1:0]          src_din,
    output logic [gw-1:0]                  grant,
    output logic                           busy,
    output logic [num_req*count_width-1:0] count
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state_q, state_d;
    logic [gw-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
    logic [num_req-1:0] ack_q, ack_d, elig;
    logic [data_width-1:0] dout_q, dout_d;
    logic [num_req*count_width-1:0] count_q, count_d;
    logic src_req_q, src_req_d, busy_q, busy_d, found;

    assign elig = req & ~mask & ~ack_q;

    // Search starts one past the last served requester so every eligible one gets a turn.
    always_comb begin
        pick = last_q;
        idx = last_q;
        found = 1'b0;
        for (int k = 1; k <= num_req; k++) begin
            idx = gw'((int'(last_q) + k) % num_req);
            if (!found && elig[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        src_req_d = src_req_q;
        ack_d = ack_q;
        dout_d = dout_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                src_req_d = 1'b1;
                state_d = FETCH;
            end
            FETCH: if (src_ack) begin
                dout_d = src_din;
                ack_d = '0;
                ack_d[grant_q] = 1'b1;
                src_req_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                ack_d = '0;
                last_d = grant_q;
                count_d[int'(grant_q)*count_width +: count_width] =
                    count_q[int'(grant_q)*count_width +: count_width] + count_width'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= gw'(num_req - 1);
            src_req_q <= 1'b0;
            ack_q <= '0;
            dout_q <= '0;
            count_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            src_req_q <= src_req_d;
            ack_q <= ack_d;
            dout_q <= dout_d;
            count_q <= count_d;
            busy_q <= busy_d;
        end
    end

    assign ack = ack_q;
    assign dout = dout_q;
    assign src_req = src_req_q;
    assign grant = grant_q;
    assign busy = busy_q;
    assign count = count_q;
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed scenarios for req_arbiter with a programmable-latency source model.
module tb_req_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] mask, req, ack;
    logic [DW-1:0] dout, src_din;
    logic src_req, src_ack;
    logic [1:0] grant;
    logic busy;
    logic [NR*CW-1:0] count;
    int checks = 0;
    int errors = 0;
    int src_delay = 0;
    int wait_cnt = 0;
    logic extra_ack = 1'b0;

    req_arbiter #(.data_width(DW), .num_req(NR), .count_width(CW)) dut (
        .clk(clk), .rst(rst), .mask(mask), .req(req), .ack(ack), .dout(dout),
        .src_req(src_req), .src_ack(src_ack), .src_din(src_din),
        .grant(grant), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;
    // Source answers src_delay cycles after src_req rises; extra_ack injects stray pulses.
    always @(posedge clk) wait_cnt <= src_req ? wait_cnt + 1 : 0;
    assign src_ack = (src_req && wait_cnt >= src_delay) || extra_ack;

    function automatic logic [CW-1:0] cnt_of(input int i);
        return count[i*CW +: CW];
    endfunction

    task automatic apply_reset();
        req = '0;
        mask = '0;
        extra_ack = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        mask = '0;
        src_din = '0;
        #2 rst = 1'b0;
        #1;
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++; if (src_req !== 1'b0) begin errors++; $display("FAIL reset_src_req got %b want 0", src_req); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", count); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        src_delay = 1;
        src_din = 32'h10;
        req = 4'b0001;
        @(negedge clk);
        checks++; if (src_req !== 1'b1) begin errors++; $display("FAIL single_src_req got %b want 1", src_req); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL single_grant got %0d want 0", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_ack_k1 got %b want 0000", ack); end
        @(negedge clk);
        req = '0;
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_ack_k1b got %b want 0000", ack); end
        @(negedge clk);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack_k2 got %b want 0001", ack); end
        checks++; if (dout !== 32'h10) begin errors++; $display("FAIL single_dout got %h want 10", dout); end
        checks++; if (src_req !== 1'b0) begin errors++; $display("FAIL single_src_req_done got %b want 0", src_req); end
        @(negedge clk);
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_ack_k3 got %b want 0000", ack); end
        checks++; if (cnt_of(0) !== 4'd1) begin errors++; $display("FAIL single_count0 got %0d want 1", cnt_of(0)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        apply_reset();
        src_delay = 0;
        req = 4'b1111;
        for (int c = 0; c < 60 && n < 12; c++) begin
            @(negedge clk);
            checks++; if (!$onehot0(ack)) begin errors++; $display("FAIL rr_onehot got %b want one-hot or zero", ack); end
            if (ack !== 4'b0) begin
                checks++;
                if (grant !== 2'(n % 4) || ack !== 4'(1 << (n % 4))) begin
                    errors++;
                    $display("FAIL rr_grant xfer %0d got grant %0d ack %b want grant %0d", n, grant, ack, n % 4);
                end
                n++;
                if (n == 12) req = '0;
            end
        end
        checks++; if (n != 12) begin errors++; $display("FAIL rr_xfers got %0d want 12", n); end
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            checks++; if (cnt_of(i) !== 4'd3) begin errors++; $display("FAIL rr_count%0d got %0d want 3", i, cnt_of(i)); end
        end
    endtask

    task automatic test_mask();
        int n = 0;
        apply_reset();
        src_delay = 0;
        mask = 4'b0101;
        req = 4'b1111;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                checks++;
                if (grant !== ((n % 2) ? 2'd3 : 2'd1)) begin
                    errors++;
                    $display("FAIL mask_grant xfer %0d got %0d want %0d", n, grant, (n % 2) ? 3 : 1);
                end
                n++;
                if (n == 6) req = '0;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL mask_xfers got %0d want 6", n); end
        @(negedge clk);
        checks++; if (count !== 16'h3030) begin errors++; $display("FAIL mask_counts got %h want 3030", count); end
        mask = '0;
    endtask

    task automatic test_stall();
        int hi = 0;
        logic got = 1'b0;
        apply_reset();
        src_delay = 10;
        src_din = 32'hABCD1234;
        req = 4'b0001;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (ack !== 4'b0) begin
                got = 1'b1;
                break;
            end
            if (src_req) hi++;
            if (hi == 3) begin
                req = '0;
                mask = 4'b0001;
            end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL stall_ack_seen got %b want 1", got); end
        checks++; if (hi != 11) begin errors++; $display("FAIL stall_src_req_cycles got %0d want 11", hi); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL stall_ack got %b want 0001", ack); end
        checks++; if (dout !== 32'hABCD1234) begin errors++; $display("FAIL stall_dout got %h want abcd1234", dout); end
        @(negedge clk);
        checks++; if (cnt_of(0) !== 4'd1) begin errors++; $display("FAIL stall_count0 got %0d want 1", cnt_of(0)); end
        mask = '0;
    endtask

    task automatic test_abort();
        src_delay = 3;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (grant !== 2'd1 || src_req !== 1'b1) begin errors++; $display("FAIL abort_pre got grant %0d src_req %b want 1 1", grant, src_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ack !== 4'b0 || src_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_ctrl got ack %b src_req %b busy %b want 0", ack, src_req, busy); end
        checks++; if (dout !== 32'h0 || grant !== 2'd0) begin errors++; $display("FAIL abort_data got dout %h grant %0d want 0", dout, grant); end
        checks++; if (count !== 16'h0) begin errors++; $display("FAIL abort_count got %h want 0", count); end
        req = '0;
        @(negedge clk);
        checks++; if (ack !== 4'b0 || src_req !== 1'b0) begin errors++; $display("FAIL abort_held got ack %b src_req %b want 0", ack, src_req); end
        rst = 1'b1;
        extra_ack = 1'b1;
        src_din = 32'hDEAD;
        @(negedge clk);
        extra_ack = 1'b0;
        checks++; if (ack !== 4'b0 || dout !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL abort_late_ack got ack %b dout %h busy %b want 0", ack, dout, busy); end
        src_delay = 0;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL abort_regrant got grant %0d busy %b want 0 1", grant, busy); end
        req = '0;
        @(negedge clk);
        checks++; if (ack !== 4'b0001 || dout !== 32'hDEAD) begin errors++; $display("FAIL abort_next_xfer got ack %b dout %h want 0001 dead", ack, dout); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int n = 0;
        apply_reset();
        src_delay = 0;
        req = 4'b0100;
        for (int c = 0; c < 10 && n < 1; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                n++;
                req = '0;
            end
        end
        n = 0;
        req = 4'b0001;
        for (int c = 0; c < 80 && n < 17; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                n++;
                if (n == 17) req = '0;
            end
        end
        checks++; if (n != 17) begin errors++; $display("FAIL wrap_xfers got %0d want 17", n); end
        @(negedge clk);
        checks++; if (cnt_of(0) !== 4'd1) begin errors++; $display("FAIL wrap_count0 got %0d want 1", cnt_of(0)); end
        checks++; if (cnt_of(2) !== 4'd1) begin errors++; $display("FAIL wrap_count2 got %0d want 1", cnt_of(2)); end
        checks++; if (cnt_of(1) !== 4'd0 || cnt_of(3) !== 4'd0) begin errors++; $display("FAIL wrap_others got %0d %0d want 0 0", cnt_of(1), cnt_of(3)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_stall();
        test_abort();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
